piso: RTL and testbench

PISO -- requirements
Module: piso

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso.sv | 39 +++
 tb/tb_piso.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared constants and types for the parallel-in / serial-out shifter.
package piso_pkg;

  localparam int WIDE_DEFAULT = 4;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/piso.sv
// Parallel-in / serial-out shift register with async active-high reset.
// Define PISO_LSB_FIRST_EN to shift LSB-first; the default build is MSB-first.
module piso
  import piso_pkg::*;
#(
  parameter int WIDE = WIDE_DEFAULT
) (
  input  logic [WIDE-1:0] go,
  input  logic            reset,
  input  logic            sh,
  input  logic            clk,
  output logic            get
);

`ifdef PISO_LSB_FIRST_EN
  localparam shift_dir_e DIR = LSB_FIRST;
`else
  localparam shift_dir_e DIR = MSB_FIRST;
`endif

  logic [WIDE-1:0] sreg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
    end else if (!sh) begin
      sreg <= go;
    end else if (DIR == LSB_FIRST) begin
      sreg <= {1'b0, sreg[WIDE-1:1]};
    end else begin
      sreg <= {sreg[WIDE-2:0], 1'b0};
    end
  end

  // Output end of the register drives the line directly; no extra flop stage.
  assign get = (DIR == LSB_FIRST) ? sreg[0] : sreg[WIDE-1];

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso at WIDE=4 and WIDE=8 against a bit-queue model.
module tb_piso;

  typedef bit bq_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic       sh;
  logic [3:0] go4;
  logic [7:0] go8;
  logic       get4;
  logic       get8;

  int tests = 0;
  int fails = 0;

  bq_t q4;
  bq_t q8;

  piso #(.WIDE(4)) dut4 (.go(go4), .reset(reset), .sh(sh), .clk(clk), .get(get4));
  piso #(.WIDE(8)) dut8 (.go(go8), .reset(reset), .sh(sh), .clk(clk), .get(get8));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // A load queues the word's bits in transmission order; each shift consumes one.
  function automatic bq_t load_q(input logic [7:0] g, input int w);
    bq_t q;
    q = {};
    for (int i = 0; i < w; i++) begin
`ifdef PISO_LSB_FIRST_EN
      q.push_back(g[i]);
`else
      q.push_back(g[w-1-i]);
`endif
    end
    return q;
  endfunction

  function automatic logic front(input bq_t q);
    return (q.size() > 0) ? q[0] : 1'b0;
  endfunction

  task automatic step(input logic s, input logic [3:0] g4, input logic [7:0] g8, input string tag);
    @(negedge clk);
    sh  = s;
    go4 = g4;
    go8 = g8;
    @(posedge clk);
    #1;
    if (s) begin
      if (q4.size() > 0) void'(q4.pop_front());
      if (q8.size() > 0) void'(q8.pop_front());
    end else begin
      q4 = load_q({4'h0, g4}, 4);
      q8 = load_q(g8, 8);
    end
    check({tag, "_w4"}, get4, front(q4));
    check({tag, "_w8"}, get8, front(q8));
  endtask

  // Reset pulse entirely between clock edges; output must clear with no edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    q4 = {};
    q8 = {};
    check({tag, "_async_w4"}, get4, 1'b0);
    check({tag, "_async_w8"}, get8, 1'b0);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp4 [6];
    logic [7:0] exp8 [10];

    reset = 1'b1;
    sh    = 1'b0;
    go4   = 4'hF;
    go8   = 8'hFF;
    #1;
    check("reset_w4", get4, 1'b0);
    check("reset_w8", get8, 1'b0);

    // Edges while reset is held must not load anything.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold_w4", get4, 1'b0);
    check("reset_hold_w8", get8, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    q4 = {};
    q8 = {};

    // Directed load then shift well past the word length.
`ifdef PISO_LSB_FIRST_EN
    exp4 = '{1, 0, 1, 1, 0, 0};
`else
    exp4 = '{1, 1, 0, 1, 0, 0};
`endif
    exp8 = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0};
    step(1'b0, 4'b1101, 8'hA5, "load");
    check("dir_load_w4", get4, exp4[0]);
    check("dir_load_w8", get8, exp8[0]);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 4'h0, 8'h00, "shift");
      if (i < 6) check($sformatf("dir_shift%0d_w4", i), get4, exp4[i]);
      check($sformatf("dir_shift%0d_w8", i), get8, exp8[i]);
    end

    // go changes while shifting are ignored.
    step(1'b0, 4'b1101, 8'h3C, "midgo_load");
    step(1'b1, 4'b1101, 8'h3C, "midgo_s1");
    step(1'b1, 4'b1101, 8'h3C, "midgo_s2");
    step(1'b1, 4'b0100, 8'hC3, "midgo_s3");
    step(1'b1, 4'b1001, 8'h99, "midgo_s4");
    step(1'b1, 4'b1001, 8'h99, "midgo_s5");

    // Reload in the middle of a shift overwrites the whole register.
    step(1'b0, 4'b1101, 8'hF0, "reload_a");
    step(1'b1, 4'h0,    8'h00, "reload_s");
    step(1'b0, 4'b1010, 8'h0F, "reload_b");
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, 8'h00, "reload_shift");

    // Repeated loads with sh held low.
    step(1'b0, 4'h3, 8'h81, "hold_load1");
    step(1'b0, 4'hC, 8'h7E, "hold_load2");

    // Async reset mid-word; subsequent shifts must emit only zeros.
    step(1'b0, 4'hF, 8'hFF, "pre_rst_load");
    step(1'b1, 4'hF, 8'hFF, "pre_rst_shift");
    pulse_reset("rst1");
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 8'hFF, "post_rst_shift");
    step(1'b0, 4'h9, 8'h96, "post_rst_load");

    // Randomized traffic with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset("rnd_rst");
      step(($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
